// File: rtl/dds_phase_gen.sv
// DDS phase accumulator and sine-ROM address generator.
// The top ADDR_WIDTH bits of the accumulator, plus a phase offset, form the ROM address.
// A new tuning word and offset are held pending and take effect at a phase wrap,
// so the output waveform never jumps mid-cycle.
//
// Handshake: there is no back-pressure. addr_valid qualifies rom_addr in the same
// cycle. data_valid is addr_valid delayed by ROM_LAT cycles, so it lines up with the
// ROM read data.
module dds_phase_gen #(
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int ROM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [ACC_WIDTH-1:0]  ftw_in,
    input  logic [ADDR_WIDTH-1:0] ofs_in,
    input  logic                  cfg_load,
    input  logic                  sync_clr,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  addr_valid,
    output logic                  data_valid,
    output logic                  wrap,
    output logic                  cfg_busy,
    output logic [1:0]            fsm_state
);

    localparam int CW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic [CW-1:0] DRAIN_LAST = CW'(ROM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           drain_cnt, drain_cnt_nxt;

    logic [ACC_WIDTH-1:0]    acc;
    logic [ACC_WIDTH-1:0]    ftw_act, ftw_pend;
    logic [ADDR_WIDTH-1:0]   ofs_act, ofs_pend;
    logic [ROM_LAT-1:0]      valid_dly;

    logic                    issue;
    logic [ACC_WIDTH:0]      sum;
    logic                    carry;
    logic                    apply;
    logic [ADDR_WIDTH-1:0]   addr_next;

    assign fsm_state  = state;
    assign data_valid = valid_dly[ROM_LAT-1];

    // Datapath decode shared by the register blocks below.
    always_comb begin
        issue     = (state == S_RUN) && en;
        sum       = {1'b0, acc} + {1'b0, ftw_act};
        // sync_clr overrides the increment, so an overflow that never lands is not a wrap
        carry     = issue && sum[ACC_WIDTH] && !sync_clr;
        // In RUN the new config waits for the wrap; elsewhere it goes in at once
        apply     = cfg_busy && ((state == S_RUN) ? carry : 1'b1);
        addr_next = acc[ACC_WIDTH-1 -: ADDR_WIDTH] + ofs_act;
    end

    // Next-state logic: DRAIN lingers ROM_LAT cycles so in-flight data_valid empties.
    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        case (state)
            S_IDLE: begin
                if (en) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!en) begin
                    state_nxt     = S_DRAIN;
                    drain_cnt_nxt = '0;
                end
            end
            S_DRAIN: begin
                if (en) begin
                    state_nxt = S_RUN;
                end else if (drain_cnt == DRAIN_LAST) begin
                    state_nxt = S_IDLE;
                end else begin
                    drain_cnt_nxt = drain_cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    // Accumulator, address issue and wrap pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            rom_addr   <= '0;
            addr_valid <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            addr_valid <= issue;
            wrap       <= carry;
            if (issue) rom_addr <= addr_next;
            if (sync_clr)   acc <= '0;
            else if (issue) acc <= sum[ACC_WIDTH-1:0];
        end
    end

    // Pending/active config; a load on the apply edge is kept for the next apply.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ftw_act  <= '0;
            ofs_act  <= '0;
            ftw_pend <= '0;
            ofs_pend <= '0;
            cfg_busy <= 1'b0;
        end else begin
            if (apply) begin
                ftw_act <= ftw_pend;
                ofs_act <= ofs_pend;
            end
            if (cfg_load) begin
                ftw_pend <= ftw_in;
                ofs_pend <= ofs_in;
                cfg_busy <= 1'b1;
            end else if (apply) begin
                cfg_busy <= 1'b0;
            end
        end
    end

    // Valid delay line matching the ROM read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_dly <= '0;
        end else begin
            valid_dly[0] <= addr_valid;
            for (int i = 1; i < ROM_LAT; i++) valid_dly[i] <= valid_dly[i-1];
        end
    end

endmodule
